// File: rtl/input_current_scheduler.sv
// Time-multiplexed input-current sequencer: one shared accumulator walks N neurons x M inputs
// against a 1-cycle synchronous weight memory and emits a saturated 8-bit current per neuron.
module input_current_scheduler #(
    parameter int M  = 24,
    parameter int N  = 8,
    parameter int AW = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    start_i,
    input  logic [M-1:0]                            input_spikes_i,
    output logic                                    weight_rd_o,
    output logic [AW-1:0]                           weight_addr_o,
    input  logic [7:0]                              weight_data_i,
    output logic [7:0]                              current_out_o,
    output logic [((N > 1) ? $clog2(N) : 1)-1:0]    neuron_idx_o,
    output logic                                    current_valid_o,
    output logic                                    busy_o,
    output logic                                    done_o
);
    // state    | meaning
    // ST_IDLE  | waiting for start
    // ST_RUN   | issuing weight reads for input j of neuron n
    // ST_DRAIN | last weight arrives, result registered
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int JW = (M > 1) ? $clog2(M) : 1;

    logic [1:0]         state_q, state_d;
    logic [NW-1:0]      n_q, n_d;
    logic [JW-1:0]      j_q, j_d;
    logic signed [13:0] acc_q, acc_d;
    logic [M-1:0]       spikes_q, spikes_d;
    logic [7:0]         cur_q, cur_d;
    logic [NW-1:0]      idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               done_q, done_d;

    logic [JW-1:0]      spike_sel;
    logic               term_en;
    logic signed [13:0] term;
    logic signed [13:0] sum;
    logic [7:0]         sat;

    // Read data always trails the address by one cycle, so it belongs to input j-1 (M-1 in DRAIN).
    always_comb begin
        spike_sel = (state_q == ST_DRAIN) ? JW'(M - 1) : (j_q - 1'b1);
        term_en   = ((state_q == ST_RUN) && (j_q != '0)) || (state_q == ST_DRAIN);
        term      = (term_en && spikes_q[spike_sel]) ?
                    {{6{weight_data_i[7]}}, weight_data_i} : 14'sd0;
        sum       = acc_q + term;
        if (sum > 14'sd127)
            sat = 8'h7F;
        else if (sum < -14'sd128)
            sat = 8'h80;
        else
            sat = sum[7:0];
    end

    always_comb begin
        state_d  = state_q;
        n_d      = n_q;
        j_d      = j_q;
        acc_d    = acc_q;
        spikes_d = spikes_q;
        cur_d    = cur_q;
        idx_d    = idx_q;
        valid_d  = 1'b0;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    n_d      = '0;
                    j_d      = '0;
                    acc_d    = '0;
                    spikes_d = input_spikes_i;
                end
            end
            ST_RUN: begin
                acc_d = sum;
                if (j_q == JW'(M - 1))
                    state_d = ST_DRAIN;
                else
                    j_d = j_q + 1'b1;
            end
            ST_DRAIN: begin
                cur_d   = sat;
                idx_d   = n_q;
                valid_d = 1'b1;
                acc_d   = '0;
                j_d     = '0;
                if (n_q == NW'(N - 1)) begin
                    state_d = ST_IDLE;
                    n_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                    n_d     = n_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                n_d     = '0;
                j_d     = '0;
                acc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            n_q      <= '0;
            j_q      <= '0;
            acc_q    <= '0;
            spikes_q <= '0;
            cur_q    <= '0;
            idx_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            n_q      <= n_d;
            j_q      <= j_d;
            acc_q    <= acc_d;
            spikes_q <= spikes_d;
            cur_q    <= cur_d;
            idx_q    <= idx_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    assign weight_rd_o     = (state_q == ST_RUN);
    assign weight_addr_o   = weight_rd_o ? (AW'(n_q) * AW'(M) + AW'(j_q)) : '0;
    assign busy_o          = (state_q != ST_IDLE);
    assign current_out_o   = cur_q;
    assign neuron_idx_o    = idx_q;
    assign current_valid_o = valid_q;
    assign done_o          = done_q;

endmodule

// File: tb/tb_input_current_scheduler.sv
// Bench for input_current_scheduler: synchronous weight memory model plus a per-neuron
// dot-product reference computed directly from the latched spikes and memory contents.
module tb_input_current_scheduler;
    localparam int M  = 24;
    localparam int N  = 8;
    localparam int AW = 8;
    localparam int NW = (N > 1) ? $clog2(N) : 1;
    localparam int PER  = M + 1;
    localparam int LAST = N * PER;

    logic          clk = 1'b0;
    logic          reset;
    logic          start_i;
    logic [M-1:0]  input_spikes_i;
    logic          weight_rd_o;
    logic [AW-1:0] weight_addr_o;
    logic [7:0]    weight_data_i = 8'h00;
    logic [7:0]    current_out_o;
    logic [NW-1:0] neuron_idx_o;
    logic          current_valid_o;
    logic          busy_o;
    logic          done_o;

    logic [7:0]    wmem [0:(1<<AW)-1];
    logic [M-1:0]  exp_sp;
    int            n_checks = 0;
    int            n_fail   = 0;

    input_current_scheduler #(.M(M), .N(N), .AW(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .input_spikes_i  (input_spikes_i),
        .weight_rd_o     (weight_rd_o),
        .weight_addr_o   (weight_addr_o),
        .weight_data_i   (weight_data_i),
        .current_out_o   (current_out_o),
        .neuron_idx_o    (neuron_idx_o),
        .current_valid_o (current_valid_o),
        .busy_o          (busy_o),
        .done_o          (done_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (weight_rd_o) weight_data_i <= wmem[weight_addr_o];

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int model_cur(input int n);
        int s = 0;
        for (int j = 0; j < M; j++)
            if (exp_sp[j]) s += int'($signed(wmem[n*M + j]));
        if (s > 127)  return 127;
        if (s < -128) return -128;
        return s;
    endfunction

    task automatic fill_const(input logic [7:0] v);
        for (int i = 0; i < (1<<AW); i++) wmem[i] = v;
    endtask

    task automatic fill_rand();
        for (int i = 0; i < (1<<AW); i++) wmem[i] = 8'($urandom);
    endtask

    task automatic start_run(input logic [M-1:0] sp);
        @(negedge clk);
        input_spikes_i = sp;
        start_i        = 1'b1;
        exp_sp         = sp;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " weight_rd"},     int'(weight_rd_o), 0);
        check({tag, " weight_addr"},   int'(weight_addr_o), 0);
        check({tag, " busy"},          int'(busy_o), 0);
        check({tag, " current_valid"}, int'(current_valid_o), 0);
        check({tag, " done"},          int'(done_o), 0);
        check({tag, " current_out"},   int'(current_out_o), 0);
        check({tag, " neuron_idx"},    int'(neuron_idx_o), 0);
    endtask

    // Called with start already driven; the next rising edge is the accepting edge E0.
    // Sample k happens in the cycle after edge E(k).
    task automatic do_run(input bit perturb, input bit chain, input logic [M-1:0] next_sp);
        bit rd_e;
        bit strobe;
        @(posedge clk);
        #1 start_i = 1'b0;
        for (int k = 0; k <= LAST; k++) begin
            @(negedge clk);
            rd_e   = (k < LAST) && ((k % PER) != M);
            strobe = (k > 0) && ((k % PER) == 0);
            check("busy", int'(busy_o), int'(k < LAST));
            check("weight_rd", int'(weight_rd_o), int'(rd_e));
            if (rd_e) check("weight_addr", int'(weight_addr_o), (k / PER) * M + (k % PER));
            check("current_valid", int'(current_valid_o), int'(strobe));
            check("done", int'(done_o), int'(k == LAST));
            if (strobe) begin
                check("neuron_idx", int'(neuron_idx_o), k / PER - 1);
                check("current_out", int'($signed(current_out_o)), model_cur(k / PER - 1));
            end
            if (perturb && k == 50) begin
                start_i        = 1'b1;
                input_spikes_i = ~input_spikes_i;
            end
            if (perturb && k == 51) start_i = 1'b0;
            if (chain && k == LAST) begin
                start_i        = 1'b1;
                input_spikes_i = next_sp;
            end
        end
    endtask

    initial begin
        logic [M-1:0] sp;
        reset          = 1'b1;
        start_i        = 1'b0;
        input_spikes_i = '0;
        exp_sp         = '0;
        fill_const(8'h00);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("idle");

        // Directed: neuron 0 -> 10+20 = 30, neuron 1 -> -7-8 = -15, remaining neurons 0.
        wmem[0]  = 8'd10;  wmem[1]  = -8'sd3; wmem[2]  = 8'd20;  wmem[3]  = 8'd5;
        wmem[24] = -8'sd7; wmem[25] = 8'd1;   wmem[26] = -8'sd8; wmem[27] = 8'd2;
        start_run(24'b0101);
        check("directed model n0", model_cur(0), 30);
        check("directed model n1", model_cur(1), -15);
        do_run(1'b0, 1'b0, '0);

        // Positive and negative saturation, chained back to back.
        fill_const(8'h7F);
        start_run('1);
        do_run(1'b0, 1'b1, '1);
        fill_const(8'h80);
        exp_sp = '1;
        do_run(1'b0, 1'b0, '0);

        // No spikes -> every current is zero.
        fill_rand();
        start_run('0);
        do_run(1'b0, 1'b0, '0);

        // Random runs with mid-run start/spike disturbance; last pair chained.
        for (int r = 0; r < 3; r++) begin
            fill_rand();
            start_run(M'($urandom));
            do_run(1'b1, 1'b0, '0);
        end
        fill_rand();
        start_run(M'($urandom));
        sp = M'($urandom);
        do_run(1'b1, 1'b1, sp);
        exp_sp = sp;
        do_run(1'b0, 1'b0, '0);

        // Reset during RUN of neuron 1 after neuron 0 has already produced a result.
        fill_const(8'h11);
        start_run('1);
        @(posedge clk);
        #1 start_i = 1'b0;
        repeat (PER + 6) @(negedge clk);
        reset = 1'b1;
        #1 check_all_zero("midrun reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            check("post-reset valid", int'(current_valid_o), 0);
            check("post-reset busy", int'(busy_o), 0);
        end

        fill_rand();
        start_run(M'($urandom));
        do_run(1'b0, 1'b0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/input_current_scheduler.md
# input_current_scheduler

Time-multiplexed sequencer that computes the saturated 8-bit input current for each of N neurons per SNN timestep using one shared signed accumulator and one synchronous weight memory. On a `start` pulse it latches the M-bit spike vector, then walks neuron by neuron and input by input, issuing weight-memory reads and accumulating only the weights whose input spike is set. It emits one current per neuron with a valid strobe and sits between the spike/delay front end and the neuron membrane update logic.

## Interface
- M, 24, inputs (spikes/weights) per neuron
- N, 8, neurons served per timestep
- AW, 8, weight address width; N*M <= 2^AW required
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  timestep request; sampled only while idle
- input_spikes  input  M  spike vector; captured on the accepted start edge
- weight_rd  output  1  weight memory read strobe
- weight_addr  output  AW  read address = n*M + j
- weight_data  input  8  signed weight, valid the cycle after the address is presented (1-cycle synchronous read)
- current_out  output  8  signed saturated input current for neuron `neuron_idx`
- neuron_idx  output  clog2(N) (min 1)  neuron index for `current_out`
- current_valid  output  1  one-cycle strobe qualifying `current_out`/`neuron_idx`
- busy  output  1  high while not IDLE
- done  output  1  one-cycle strobe: all N currents emitted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: `start`=1 at an edge → RUN; n=0, j=0, acc=0, spikes latched.
- RUN, input index j: `weight_rd`=1, `weight_addr`=n*M+j (combinational from counters). j=M-1 → DRAIN at the next edge; otherwise j+1.
- DRAIN: `weight_rd`=0. At the next edge, neuron n result registered to `current_out`, n to `neuron_idx`, `current_valid`=1, acc cleared.
  - n<N-1: → RUN with n+1, j=0.
  - n=N-1: → IDLE, `done`=1.
- Accumulation: in every RUN cycle with j>=1 and in every DRAIN cycle, `weight_data` belongs to input j-1 (DRAIN: M-1). If the latched spike for that input is 1, acc += sign-extended `weight_data`; otherwise acc is unchanged.
- Arithmetic:
  - acc is 14-bit signed; no internal overflow for M <= 64.
  - The result is acc plus the DRAIN-cycle term, saturated: >127 → 0x7F, <-128 → 0x80, else low 8 bits.
- `start` while busy is ignored and does not queue. Changes to `input_spikes` after capture have no effect.
- Reset (any time, including mid-run): state IDLE, n=j=0, acc=0, latched spikes 0. All outputs are 0, including `current_out`, `neuron_idx`, `current_valid`, `done`, `busy`, `weight_rd` and `weight_addr`. No partial result is emitted.

## Timing
- Start accepted at edge E0. RUN cycle j of neuron n occupies the cycle after edge E(n*(M+1)+j).
- Per neuron: M RUN cycles + 1 DRAIN cycle = M+1 cycles.
- `current_valid` for neuron n is high during the cycle after edge E((n+1)*(M+1)). It overlaps RUN j=0 of neuron n+1.
- `done` is coincident with the `current_valid` of neuron N-1, in the cycle after E(N*(M+1)). With defaults that is edge E200.
- `busy` is high from the cycle after E0 through the last DRAIN cycle, and low in the `done` cycle. A `start` sampled in the `done` cycle is accepted, so back-to-back timesteps have no gap.
- `current_out`/`neuron_idx` hold their last value between strobes.

## Test plan
- M=4,N=2,AW=3; spikes=4'b0101; weights n0=[10,-3,20,5], n1=[-7,1,-8,2] → strobe1 n=0 cur=30; strobe2 n=1 cur=-15; `done` with strobe2, 10 cycles after start.
- Defaults, all spikes 1, all weights 127 → 8 strobes of 0x7F; all weights -128 → 8 strobes of 0x80; `done` at cycle 200.
- Spikes all 0, arbitrary weights → all currents 0. The `weight_addr` sequence is 0..N*M-1, one address per RUN cycle, with `weight_rd` low in DRAIN cycles.
- `start` pulsed mid-run, and `input_spikes` changed after capture → results and strobe count unchanged; a new `start` in the `done` cycle begins the next run immediately.
- Reset asserted in RUN of neuron 1 → all outputs 0 immediately, no further strobes; a subsequent `start` yields a correct full run.
